// File: rtl/xpeak_pkg.sv
// Shared types and constants for the frame peak detector.
// Default widths mirror the coarse magnitude estimator output path.
package xpeak_pkg;

  localparam int XPK_BWID = 16;
  localparam int XPK_NWID = 10;

  // iv_len value that stands for the maximum frame length 2^NWID
  localparam int LEN_ZERO_CODE = 0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SEARCH = 1'b1
  } xpk_state_e;

endpackage

// File: rtl/xpeak_detect.sv
// Frame-based peak search on the magnitude stream: per frame, reports the largest
// magnitude, the index of its first occurrence, and whether it met the threshold.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | waiting for a start-of-frame sample; other samples ignored
//   ST_SEARCH | frame in progress; tracking running peak and sample count
module xpeak_detect
  import xpeak_pkg::*;
#(
  parameter int BWID = XPK_BWID,
  parameter int NWID = XPK_NWID
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BWID-1:0] iv_abs,
  input  logic            i_nd,
  input  logic            i_sof,
  input  logic [NWID-1:0] iv_len,
  input  logic [BWID-1:0] iv_thresh,
  output logic [BWID-1:0] ov_peak,
  output logic [NWID-1:0] ov_index,
  output logic            o_found,
  output logic            o_dv,
  output logic            o_abort
);

  xpk_state_e      r_state;
  logic [BWID-1:0] r_peak;
  logic [NWID-1:0] r_pidx;
  logic [NWID:0]   r_cnt;
  logic [NWID:0]   r_len;
  logic [BWID-1:0] r_thresh;

  logic [NWID:0]   w_sof_len;
  logic            w_sof_single;
  logic            w_gt;
  logic [BWID-1:0] w_sel_peak;
  logic [NWID-1:0] w_sel_idx;
  logic [NWID:0]   w_cnt_nxt;
  logic            w_last;

  // One extra bit on length/count so that the zero code terminates at 2^NWID.
  assign w_sof_len    = (iv_len == NWID'(LEN_ZERO_CODE)) ? {1'b1, {NWID{1'b0}}}
                                                         : {1'b0, iv_len};
  assign w_sof_single = (w_sof_len == (NWID+1)'(1));

  assign w_gt       = (iv_abs > r_peak);
  assign w_sel_peak = w_gt ? iv_abs : r_peak;
  assign w_sel_idx  = w_gt ? r_cnt[NWID-1:0] : r_pidx;
  assign w_cnt_nxt  = r_cnt + (NWID+1)'(1);
  assign w_last     = (w_cnt_nxt == r_len);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_peak   <= '0;
      r_pidx   <= '0;
      r_cnt    <= '0;
      r_len    <= '0;
      r_thresh <= '0;
      ov_peak  <= '0;
      ov_index <= '0;
      o_found  <= 1'b0;
      o_dv     <= 1'b0;
      o_abort  <= 1'b0;
    end else begin
      o_dv    <= 1'b0;
      o_abort <= 1'b0;
      if (i_nd && i_sof) begin
        r_len    <= w_sof_len;
        r_thresh <= iv_thresh;
        r_peak   <= iv_abs;
        r_pidx   <= '0;
        r_cnt    <= (NWID+1)'(1);
        // A length-1 frame completes on its SOF sample; if that SOF also cut a
        // frame short, the completion pulse wins so o_dv/o_abort stay exclusive.
        if (w_sof_single) begin
          ov_peak  <= iv_abs;
          ov_index <= '0;
          o_found  <= (iv_abs >= iv_thresh);
          o_dv     <= 1'b1;
          r_state  <= ST_IDLE;
        end else begin
          o_abort  <= (r_state == ST_SEARCH);
          r_state  <= ST_SEARCH;
        end
      end else if (i_nd && (r_state == ST_SEARCH)) begin
        r_peak <= w_sel_peak;
        r_pidx <= w_sel_idx;
        r_cnt  <= w_cnt_nxt;
        if (w_last) begin
          ov_peak  <= w_sel_peak;
          ov_index <= w_sel_idx;
          o_found  <= (w_sel_peak >= r_thresh);
          o_dv     <= 1'b1;
          r_state  <= ST_IDLE;
        end
      end
    end
  end

endmodule
